// File: rtl/pc_branch_unit.sv
// Program counter and control-transfer stage for the 16-bit single-cycle core.
// Owns the architectural PC, evaluates branch conditions against the ALU's
// registered N/Z/V flags, tracks the RUN/HALT state and counts taken
// transfers with a saturating counter.
//
// Flow control: there is no valid/ready pair on this block. Every rising edge
// with stall=0 consumes the decoder's control fields for the instruction at
// pc. A cycle with stall=1 consumes nothing and all state holds. rst=1 takes
// priority over stall and over every control input.
module pc_branch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br,
  input  logic             jal,
  input  logic             jr,
  input  logic             hlt,
  input  logic [2:0]       cond,
  input  logic [8:0]       br_off,
  input  logic [11:0]      jmp_off,
  input  logic [15:0]      jr_target,
  input  logic             N,
  input  logic             Z,
  input  logic             V,
  output logic [15:0]      pc,
  output logic [15:0]      pc_plus1,
  output logic             prev_br_ctrl,
  output logic             halted,
  output logic [CNT_W-1:0] taken_cnt,
  output logic             dbg_state
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        run_active;
  logic        take;
  logic        taken;
  logic [15:0] pc_nxt;
  logic [15:0] br_off_ext;
  logic [15:0] jmp_off_ext;

  // Offsets are in words and signed; widen them to the PC width.
  assign br_off_ext  = {{7{br_off[8]}}, br_off};
  assign jmp_off_ext = {{4{jmp_off[11]}}, jmp_off};
  assign pc_plus1    = pc + 16'd1;

  // State register: reset wins, a stall freezes the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
    end else if (!stall) begin
      state <= state_nxt;
    end
  end

  // Next state: an accepted hlt enters HALT; only reset leaves it.
  always_comb begin
    state_nxt = state;
    if (state == S_RUN && hlt) begin
      state_nxt = S_HALT;
    end
  end

  // FSM outputs: halted comes straight from the state register.
  always_comb begin
    halted     = (state == S_HALT);
    dbg_state  = state;
    run_active = (state == S_RUN) && !stall;
  end

  // Branch condition evaluation from the registered ALU flags.
  always_comb begin
    take = 1'b0;
    case (cond)
      3'b000:  take = !Z;
      3'b001:  take = Z;
      3'b010:  take = !Z && !N;
      3'b011:  take = N;
      3'b100:  take = Z || !N;
      3'b101:  take = N || Z;
      3'b110:  take = V;
      default: take = 1'b1;
    endcase
  end

  // Next PC in RUN: hlt > jr > jal > taken br > sequential.
  always_comb begin
    pc_nxt = pc_plus1;
    taken  = 1'b0;
    if (hlt) begin
      pc_nxt = pc;
    end else if (jr) begin
      pc_nxt = jr_target;
      taken  = 1'b1;
    end else if (jal) begin
      pc_nxt = pc_plus1 + jmp_off_ext;
      taken  = 1'b1;
    end else if (br && take) begin
      pc_nxt = pc_plus1 + br_off_ext;
      taken  = 1'b1;
    end
  end

  // PC, flag-hold qualifier and taken counter; HALT freezes pc and clears
  // the qualifier, a stall holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      prev_br_ctrl <= 1'b0;
      taken_cnt    <= '0;
    end else if (run_active) begin
      pc           <= pc_nxt;
      prev_br_ctrl <= taken;
      if (taken && !(&taken_cnt)) begin
        taken_cnt <= taken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else if (!stall) begin
      prev_br_ctrl <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: a 16-bit counter instance and a 4-bit counter
// instance share one stimulus stream; a reference model predicts the
// post-edge outputs of both and a monitor compares them every cycle.
module tb_pc_branch_unit;

  localparam int EW = 16 + 16 + 1 + 1 + 16 + 4;

  logic        clk = 1'b0;
  logic        rst, stall, br, jal, jr, hlt, N, Z, V;
  logic [2:0]  cond;
  logic [8:0]  br_off;
  logic [11:0] jmp_off;
  logic [15:0] jr_target;

  logic [15:0] pc_a, pc_plus1_a, pc_b, pc_plus1_b;
  logic        prev_a, halted_a, dbg_a, prev_b, halted_b, dbg_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int cycle_no = 0;

  // model state
  int m_pc, m_cnt, m_cnt4;
  bit m_prev, m_halt;

  pc_branch_unit #(.RESET_PC(16'h0000), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br(br), .jal(jal), .jr(jr), .hlt(hlt),
    .cond(cond), .br_off(br_off), .jmp_off(jmp_off), .jr_target(jr_target),
    .N(N), .Z(Z), .V(V), .pc(pc_a), .pc_plus1(pc_plus1_a), .prev_br_ctrl(prev_a),
    .halted(halted_a), .taken_cnt(cnt_a), .dbg_state(dbg_a));

  pc_branch_unit #(.RESET_PC(16'h0000), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .br(br), .jal(jal), .jr(jr), .hlt(hlt),
    .cond(cond), .br_off(br_off), .jmp_off(jmp_off), .jr_target(jr_target),
    .N(N), .Z(Z), .V(V), .pc(pc_b), .pc_plus1(pc_plus1_b), .prev_br_ctrl(prev_b),
    .halted(halted_b), .taken_cnt(cnt_b), .dbg_state(dbg_b));

  // clock / reset block
  always #5 clk = ~clk;

  // condition table written directly from the ISA description
  function automatic bit cond_take(input int c, input bit n, input bit z, input bit v);
    case (c)
      0: return z == 0;
      1: return z == 1;
      2: return z == 0 && n == 0;
      3: return n == 1;
      4: return z == 1 || n == 0;
      5: return n == 1 || z == 1;
      6: return v == 1;
      default: return 1;
    endcase
  endfunction

  function automatic int signed_val(input int raw, input int bits);
    if (raw >= (1 << (bits - 1))) return raw - (1 << bits);
    return raw;
  endfunction

  task automatic clear_inputs();
    rst = 0; stall = 0; br = 0; jal = 0; jr = 0; hlt = 0;
    cond = 3'd0; br_off = 9'd0; jmp_off = 12'd0; jr_target = 16'd0;
    N = 0; Z = 0; V = 0;
  endtask

  // driver: inputs are already set; advance the model, push the expected
  // post-edge outputs, then wait for the next falling edge
  task automatic tick();
    bit t;
    int p1;
    if (rst) begin
      m_pc = 0; m_prev = 0; m_halt = 0; m_cnt = 0; m_cnt4 = 0;
    end else if (!stall) begin
      if (m_halt) begin
        m_prev = 0;
      end else begin
        t  = 0;
        p1 = (m_pc + 1) % 65536;
        if (hlt) begin
          m_halt = 1;
        end else if (jr) begin
          m_pc = int'(jr_target); t = 1;
        end else if (jal) begin
          m_pc = (p1 + signed_val(int'(jmp_off), 12) + 65536) % 65536; t = 1;
        end else if (br && cond_take(int'(cond), N, Z, V)) begin
          m_pc = (p1 + signed_val(int'(br_off), 9) + 65536) % 65536; t = 1;
        end else begin
          m_pc = p1;
        end
        m_prev = t;
        if (t) begin
          if (m_cnt < 65535) m_cnt = m_cnt + 1;
          if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
        end
      end
    end
    exp_q.push_back({16'(m_pc), 16'((m_pc + 1) % 65536), m_prev, m_halt,
                     16'(m_cnt), 4'(m_cnt4)});
    @(negedge clk);
  endtask

  task automatic jump_to(input logic [15:0] a);
    clear_inputs(); jr = 1; jr_target = a; tick();
  endtask

  // monitor / scoreboard: compare one expected entry after every edge
  logic [EW-1:0] got, exp_v;
  always @(posedge clk) begin
    #1;
    cycle_no++;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got = {pc_a, pc_plus1_a, prev_a, halted_a, cnt_a, cnt_b};
      checks++;
      if (got !== exp_v || pc_b !== exp_v[EW-1 -: 16] || halted_b !== exp_v[20]) begin
        failures++;
        $display("FAIL state cyc=%0d got pc=%h pc1=%h prev=%b halt=%b cnt=%h cnt4=%h pc4=%h halt4=%b exp pc=%h pc1=%h prev=%b halt=%b cnt=%h cnt4=%h",
                 cycle_no, pc_a, pc_plus1_a, prev_a, halted_a, cnt_a, cnt_b, pc_b, halted_b,
                 exp_v[53:38], exp_v[37:22], exp_v[21], exp_v[20], exp_v[19:4], exp_v[3:0]);
      end
    end
  end

  initial begin
    clear_inputs();
    rst = 1;
    @(negedge clk);
    // 1: reset then run
    tick(); tick();
    clear_inputs();
    tick(); tick(); tick();

    // 2: conditional branch taken / not taken at 0010
    jump_to(16'h000F);
    clear_inputs(); tick();                       // pc -> 0010
    clear_inputs(); br = 1; cond = 3'b001; Z = 1; br_off = 9'h1FC; tick();
    clear_inputs(); tick();
    jump_to(16'h0010);
    clear_inputs(); br = 1; cond = 3'b001; Z = 0; br_off = 9'h1FC; tick();

    // 3: condition sweep, every cond against every flag combination
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        clear_inputs(); br = 1; cond = 3'(c);
        N = f[2]; Z = f[1]; V = f[0]; br_off = 9'h010;
        tick();
      end
    end

    // 4: wrap, JAL at 0005, JR priority over unconditional branch
    jump_to(16'hFFFF);
    clear_inputs(); tick();
    jump_to(16'h0005);
    clear_inputs(); jal = 1; jmp_off = 12'h7FF; tick();
    clear_inputs(); jr = 1; jr_target = 16'hABCD; br = 1; cond = 3'b111; tick();
    clear_inputs(); jal = 1; jmp_off = 12'h800; tick();

    // 5: stall, halt, ignored controls, reset out of HALT
    clear_inputs(); stall = 1; jal = 1; jmp_off = 12'h123; tick();
    jump_to(16'h0020);
    clear_inputs(); stall = 1; hlt = 1; tick();
    clear_inputs(); hlt = 1; tick();
    clear_inputs(); br = 1; cond = 3'b111; br_off = 9'h005; tick();
    clear_inputs(); jal = 1; jmp_off = 12'h010; tick();
    clear_inputs(); jr = 1; jr_target = 16'h1234; tick();
    clear_inputs(); rst = 1; stall = 1; tick();
    clear_inputs(); tick();

    // 6: counter saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) begin
      clear_inputs(); br = 1; cond = 3'b111; br_off = 9'(i); tick();
    end

    // randomized stream
    for (int i = 0; i < 600; i++) begin
      clear_inputs();
      rst       = ($urandom_range(0, 59) == 0);
      stall     = ($urandom_range(0, 7) == 0);
      hlt       = ($urandom_range(0, 39) == 0);
      jr        = ($urandom_range(0, 9) == 0);
      jal       = ($urandom_range(0, 7) == 0);
      br        = ($urandom_range(0, 2) == 0);
      cond      = 3'($urandom_range(0, 7));
      br_off    = 9'($urandom);
      jmp_off   = 12'($urandom);
      jr_target = 16'($urandom);
      N = 1'($urandom); Z = 1'($urandom); V = 1'($urandom);
      tick();
    end

    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending entries, exp 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
